// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch stage owning the architectural PC
// Optional HLT stop: define PC_FETCH_HALT_EN.
module pc_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  input  logic        id_ready,
  output logic        halted
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        capture;
  logic        halt_hit;

`ifdef PC_FETCH_HALT_EN
  assign halt_hit = (if_instr[15:12] == 4'hF);
  assign halted   = (state_q == HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // Every output is a register or a pure decode of the state register.
  assign imem_req  = (state_q == FETCH);
  assign if_valid  = (state_q == HOLD);
  assign imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    if (redirect) begin
      // Squashes any returning data or held instruction; bit 0 is forced low.
      state_d = FETCH;
      pc_d    = redirect_pc & 16'hFFFE;
    end else begin
      case (state_q)
        BOOT:  state_d = FETCH;
        FETCH: begin
          if (imem_rdy) begin
            capture = 1'b1;
            pc_d    = pc_q + 16'd2;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (id_ready) state_d = halt_hit ? HALT : FETCH;
        end
        HALT:    state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= 16'h0000;
      if_instr    <= 16'h0000;
      if_pc       <= 16'h0000;
      if_pc_plus2 <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (capture) begin
        if_instr    <= imem_data;
        if_pc       <= pc_q;
        if_pc_plus2 <= pc_q + 16'd2;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed table-driven bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        id_ready;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory returns 0x1000+addr, except an HLT word at 0x0010.
  assign imem_data = (imem_addr == 16'h0010) ? 16'hF000 : (16'h1000 + imem_addr);

  pc_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus2 (if_pc_plus2),
    .id_ready    (id_ready),
    .halted      (halted)
  );

  typedef struct {
    logic        rd;
    logic [15:0] rpc;
    logic        rdy;
    logic        idr;
    logic        req;
    logic [15:0] addr;
    logic        val;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc2;
    logic        hlt;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(logic rd, logic [15:0] rpc, logic rdy, logic idr,
                              logic req, logic [15:0] addr, logic val,
                              logic [15:0] instr, logic [15:0] pc, logic [15:0] pc2,
                              logic hlt);
    row_t r;
    r.rd = rd; r.rpc = rpc; r.rdy = rdy; r.idr = idr;
    r.req = req; r.addr = addr; r.val = val; r.instr = instr;
    r.pc = pc; r.pc2 = pc2; r.hlt = hlt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input row_t r);
    chk({tag, " imem_req"},    {15'd0, imem_req}, {15'd0, r.req});
    chk({tag, " imem_addr"},   imem_addr,         r.addr);
    chk({tag, " if_valid"},    {15'd0, if_valid}, {15'd0, r.val});
    chk({tag, " if_instr"},    if_instr,          r.instr);
    chk({tag, " if_pc"},       if_pc,             r.pc);
    chk({tag, " if_pc_plus2"}, if_pc_plus2,       r.pc2);
    chk({tag, " halted"},      {15'd0, halted},   {15'd0, r.hlt});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_rdy = 1'b1; id_ready = 1'b1;

    // streaming
    tbl.push_back(mk(0,16'h0000,1,1, 1,16'h0000,0,16'h0000,16'h0000,16'h0000,0));
    tbl.push_back(mk(0,16'h0000,1,1, 0,16'h0002,1,16'h1000,16'h0000,16'h0002,0));
    tbl.push_back(mk(0,16'h0000,1,1, 1,16'h0002,0,16'h1000,16'h0000,16'h0002,0));
    tbl.push_back(mk(0,16'h0000,1,1, 0,16'h0004,1,16'h1002,16'h0002,16'h0004,0));
    tbl.push_back(mk(0,16'h0000,1,1, 1,16'h0004,0,16'h1002,16'h0002,16'h0004,0));
    tbl.push_back(mk(0,16'h0000,1,1, 0,16'h0006,1,16'h1004,16'h0004,16'h0006,0));
    tbl.push_back(mk(0,16'h0000,1,1, 1,16'h0006,0,16'h1004,16'h0004,16'h0006,0));
    // memory wait then decode backpressure
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,16'h0000,0,0, 1,16'h0006,0,16'h1004,16'h0004,16'h0006,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,16'h0000,1,0, 0,16'h0008,1,16'h1006,16'h0006,16'h0008,0));
    tbl.push_back(mk(0,16'h0000,1,1, 1,16'h0008,0,16'h1006,16'h0006,16'h0008,0));
    // redirect racing a memory response, then redirect in HOLD with id_ready
    tbl.push_back(mk(1,16'h0041,1,1, 1,16'h0040,0,16'h1006,16'h0006,16'h0008,0));
    tbl.push_back(mk(0,16'h0000,1,0, 0,16'h0042,1,16'h1040,16'h0040,16'h0042,0));
    tbl.push_back(mk(1,16'h0020,1,1, 1,16'h0020,0,16'h1040,16'h0040,16'h0042,0));
    tbl.push_back(mk(0,16'h0000,1,1, 0,16'h0022,1,16'h1020,16'h0020,16'h0022,0));
    tbl.push_back(mk(0,16'h0000,1,1, 1,16'h0022,0,16'h1020,16'h0020,16'h0022,0));
    // PC wrap
    tbl.push_back(mk(1,16'hFFFE,0,1, 1,16'hFFFE,0,16'h1020,16'h0020,16'h0022,0));
    tbl.push_back(mk(0,16'h0000,1,0, 0,16'h0000,1,16'h0FFE,16'hFFFE,16'h0000,0));
    tbl.push_back(mk(0,16'h0000,1,1, 1,16'h0000,0,16'h0FFE,16'hFFFE,16'h0000,0));
    // HLT opcode at 0x0010
    tbl.push_back(mk(1,16'h0010,1,1, 1,16'h0010,0,16'h0FFE,16'hFFFE,16'h0000,0));
    tbl.push_back(mk(0,16'h0000,1,0, 0,16'h0012,1,16'hF000,16'h0010,16'h0012,0));
`ifdef PC_FETCH_HALT_EN
    tbl.push_back(mk(0,16'h0000,1,1, 0,16'h0012,0,16'hF000,16'h0010,16'h0012,1));
    tbl.push_back(mk(0,16'h0000,1,1, 0,16'h0012,0,16'hF000,16'h0010,16'h0012,1));
    tbl.push_back(mk(1,16'h0100,1,1, 1,16'h0100,0,16'hF000,16'h0010,16'h0012,0));
`else
    tbl.push_back(mk(0,16'h0000,1,1, 1,16'h0012,0,16'hF000,16'h0010,16'h0012,0));
    tbl.push_back(mk(0,16'h0000,1,1, 0,16'h0014,1,16'h1012,16'h0012,16'h0014,0));
    tbl.push_back(mk(1,16'h0100,1,1, 1,16'h0100,0,16'h1012,16'h0012,16'h0014,0));
`endif
    tbl.push_back(mk(0,16'h0000,1,1, 0,16'h0102,1,16'h1100,16'h0100,16'h0102,0));

    step();
    step();
    chk_all("reset", mk(0,16'h0,0,0, 0,16'h0000,0,16'h0000,16'h0000,16'h0000,0));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
      imem_rdy = tbl[i].rdy; id_ready = tbl[i].idr;
      step();
      chk_all($sformatf("row%0d", i), tbl[i]);
    end

    // async reset in the middle of an outstanding request
    redirect = 1'b0; imem_rdy = 1'b0; id_ready = 1'b1;
    step();
    chk("pre-reset fetch req", {15'd0, imem_req}, 16'd1);
    chk("pre-reset fetch addr", imem_addr, 16'h0102);
    imem_rdy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async imem_req", {15'd0, imem_req}, 16'd0);
    chk("async if_valid", {15'd0, if_valid}, 16'd0);
    chk("async imem_addr", imem_addr, 16'h0000);
    chk("async if_instr", if_instr, 16'h0000);
    step();
    chk("reset held instr", if_instr, 16'h0000);
    rst_n = 1'b1;
    chk("boot no req", {15'd0, imem_req}, 16'd0);
    step();
    chk("first req cycle1", {15'd0, imem_req}, 16'd1);
    chk("first addr", imem_addr, 16'h0000);

    // redirect while in BOOT
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0031;
    step();
    redirect = 1'b0;
    chk("boot redirect req", {15'd0, imem_req}, 16'd1);
    chk("boot redirect addr", imem_addr, 16'h0030);
    step();
    chk("boot redirect valid", {15'd0, if_valid}, 16'd1);
    chk("boot redirect instr", if_instr, 16'h1030);
    chk("boot redirect pc2", if_pc_plus2, 16'h0032);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage that owns the architectural PC register. It issues one instruction-memory read at a time and presents the fetched word, its PC and PC+2 to decode with a valid/ready handshake. It applies redirects from the branch-resolution path (PC_control output), which supply the taken-branch target. It also optionally stops fetching on a HLT opcode.

## Interface
- Parameters: none.
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- redirect  input  1  taken branch/jump resolved; load redirect_pc and squash in-flight fetch
- redirect_pc  input  16  redirect target from branch resolution; bit 0 ignored (forced 0)
- imem_req  output  1  read request to instruction memory
- imem_addr  output  16  read address (= current PC)
- imem_rdy  input  1  instruction memory returns data this cycle
- imem_data  input  16  instruction word, valid when imem_rdy=1
- if_valid  output  1  fetched instruction is being offered to decode
- if_instr  output  16  fetched instruction
- if_pc  output  16  address of if_instr
- if_pc_plus2  output  16  if_pc + 2 (mod 2^16), fed to PC_control as its PC_in base
- id_ready  input  1  decode accepts the offered instruction this cycle
- halted  output  1  fetch stopped on HLT

## Operation
- States: BOOT, FETCH, HOLD, HALT. Reset enters BOOT with pc=0x0000. if_instr, if_pc and if_pc_plus2 reset to 0x0000. imem_req, if_valid and halted reset to 0.
- BOOT: all outputs inactive. The next cycle is unconditionally FETCH, unless redirect is asserted, in which case pc=redirect_pc and the next state is still FETCH.
- FETCH: imem_req=1 and imem_addr=pc.
  - If imem_rdy=1 and there is no redirect: capture imem_data, pc and pc+2 into the output registers, set pc <= pc+2, and go to HOLD.
  - If imem_rdy=0: stay in FETCH and hold the address.
- HOLD: if_valid=1 and imem_req=0. If id_ready=1, go to FETCH, or to HALT if the halt condition holds. If id_ready=0, stay in HOLD with the outputs stable.
- HALT: imem_req=0, if_valid=0, halted=1.
- Redirect has priority over every other event in BOOT, FETCH, HOLD and HALT:
  - pc <= {redirect_pc[15:1],1'b0} and the next state is FETCH.
  - FETCH with imem_rdy=1 in the same cycle: the returned data is discarded.
  - HOLD: the held instruction is dropped, even if id_ready=1 in the same cycle (decode must also ignore it; the squash is owned by the redirect source). if_valid is 0 in the next cycle.
  - HALT: halted deasserts in the next cycle. An older branch can squash a speculatively fetched HLT.
- PC arithmetic is 16-bit unsigned and wraps: 0xFFFE + 2 = 0x0000. No exception is raised.
- Only one outstanding memory request exists at any time. No request is issued in HOLD.

## Timing
- Fetch latency: FETCH with imem_rdy=1 in cycle N gives if_valid=1 in cycle N+1.
- Peak throughput: one instruction per 2 cycles (FETCH and HOLD alternate) when imem_rdy=1 and id_ready=1.
- First request after reset release: BOOT in cycle 0 and imem_req=1 in cycle 1.
- Redirect in cycle N gives imem_req=1 with imem_addr=target in cycle N+1.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- rst_n assertion mid-operation (in any state, or mid-request) immediately forces the reset values. An outstanding memory response is ignored.

## Configuration
- PC_FETCH_HALT_EN defined: when an instruction with if_instr[15:12]==4'hF is accepted (HOLD with id_ready=1 and no redirect), the next state is HALT.
- PC_FETCH_HALT_EN undefined: opcode 4'hF is an ordinary instruction and fetch continues at pc+2. The HALT state is unreachable and halted is tied to 0.

## Test plan
- Reset and streaming: release rst_n with imem_rdy=1, id_ready=1, and memory returning 0x1000+addr. Required: imem_addr sequence 0x0000, 0x0002, 0x0004, with if_valid every second cycle and if_pc_plus2 = if_pc+2.
- Backpressure and memory wait: hold imem_rdy=0 for 3 cycles, then id_ready=0 for 4 cycles. Required: imem_addr stable during the wait, and if_instr and if_pc stable while if_valid=1, with no new imem_req.
- Redirect races: redirect=1 with redirect_pc=0x0041 in the same cycle as imem_rdy=1. Required: data dropped and the next imem_addr=0x0040. Then redirect while in HOLD with id_ready=1: if_valid=0 in the next cycle.
- Halt (PC_FETCH_HALT_EN defined): fetch 0xF000 at 0x0010 and accept it. Required: halted=1 and imem_req=0 from then on. A later redirect to 0x0100 resumes fetch at 0x0100 with halted=0.
- Wrap and async reset: redirect to 0xFFFE and fetch. Required: the next imem_addr=0x0000. Assert rst_n=0 mid-FETCH. Required: imem_req=0 and if_valid=0 immediately, without waiting for a clock edge.
